// File: rtl/exe_stage_mdu_if.sv
// exe_stage_mdu_if: ID->EX->MEM handshake, forwarding and data-SRAM signals of the EX stage
interface exe_stage_mdu_if #(parameter int XLEN = 32);
  localparam int NB = XLEN / 8;
  localparam int DS_WD = 4 * XLEN + 27;
  localparam int MS_WD = 2 * XLEN + 12;
  localparam int FW_WD = XLEN + 8;
  logic ms_allowin, es_allowin, ds_to_es_valid, flush, es_to_ms_valid, data_sram_en;
  logic [DS_WD-1:0] ds_to_es_bus;
  logic [MS_WD-1:0] es_to_ms_bus;
  logic [FW_WD-1:0] es_to_ds_bus;
  logic [NB-1:0] data_sram_wen;
  logic [XLEN-1:0] data_sram_addr, data_sram_wdata;
  modport master(
    input ms_allowin, ds_to_es_valid, ds_to_es_bus, flush,
    output es_allowin, es_to_ms_valid, es_to_ms_bus, es_to_ds_bus,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );
  modport slave(
    output ms_allowin, ds_to_es_valid, ds_to_es_bus, flush,
    input es_allowin, es_to_ms_valid, es_to_ms_bus, es_to_ds_bus,
    input data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/exe_stage_mdu.sv
// exe_stage_mdu: EX stage with ALU, iterative restoring divider, store strobes and misalignment check
module exe_stage_mdu #(
  parameter int XLEN = 32
) (
  input logic clk,
  input logic reset,
  exe_stage_mdu_if.master bus
);
  localparam int NB = XLEN / 8;
  localparam int AB = $clog2(NB);
  localparam int SW = $clog2(XLEN);
  localparam int DS_WD = 4 * XLEN + 27;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic es_valid_q;
  logic [DS_WD-1:0] ds_q;
  logic [XLEN-1:0] r_q, r_d, q_q, q_d, d_q, d_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [11:0] alu_op;
  logic sgn, rem, div_en, re, we, src1_is_pc, src2_is_imm, gr_we;
  logic [1:0] size;
  logic [4:0] dest;
  logic [XLEN-1:0] imm, rj, rkd, pc;
  logic [XLEN-1:0] src1, src2, sra_res, alu_res, q_fix, r_fix, result, wdata;
  logic [XLEN:0] step_t, step_df;
  logic [3:0] bytes;
  logic [NB:0] lane;
  logic es_ready_go, ale, mem_en;
  assign {alu_op, sgn, rem, div_en, re, we, size, src1_is_pc, src2_is_imm, gr_we, dest,
          imm, rj, rkd, pc} = ds_q;
  assign src1 = src1_is_pc ? pc : rj;
  assign src2 = src2_is_imm ? imm : rkd;
  assign sra_res = $signed(src1) >>> src2[SW-1:0];
  assign alu_res = alu_op[0]  ? src1 + src2 :
                   alu_op[1]  ? src1 - src2 :
                   alu_op[2]  ? XLEN'($signed(src1) < $signed(src2)) :
                   alu_op[3]  ? XLEN'(src1 < src2) :
                   alu_op[4]  ? src1 & src2 :
                   alu_op[5]  ? ~(src1 | src2) :
                   alu_op[6]  ? src1 | src2 :
                   alu_op[7]  ? src1 ^ src2 :
                   alu_op[8]  ? src1 << src2[SW-1:0] :
                   alu_op[9]  ? src1 >> src2[SW-1:0] :
                   alu_op[10] ? sra_res :
                   alu_op[11] ? src2 : '0;
  // rj/rkd stay in ds_q for the whole divide, so sign fix-up reads them directly
  assign q_fix = (rkd == '0) ? '1 : (sgn & (rj[XLEN-1] ^ rkd[XLEN-1])) ? -q_q : q_q;
  assign r_fix = (rkd == '0) ? rj : (sgn & rj[XLEN-1]) ? -r_q : r_q;
  assign result = div_en ? (rem ? r_fix : q_fix) : alu_res;
  assign es_ready_go = !div_en | (state_q == DONE);
  assign bus.es_allowin = !es_valid_q | (es_ready_go & bus.ms_allowin);
  assign bus.es_to_ms_valid = es_valid_q & es_ready_go & !bus.flush;
  assign step_t = {r_q, q_q[XLEN-1]};
  assign step_df = step_t - {1'b0, d_q};
  always_comb begin
    state_d = state_q;
    r_d = r_q;
    q_d = q_q;
    d_d = d_q;
    cnt_d = cnt_q;
    if (bus.flush) state_d = IDLE;
    else if (state_q == IDLE && es_valid_q && div_en) begin
      state_d = BUSY;
      r_d = '0;
      q_d = (sgn & rj[XLEN-1]) ? -rj : rj;
      d_d = (sgn & rkd[XLEN-1]) ? -rkd : rkd;
      cnt_d = SW'(XLEN - 1);
    end else if (state_q == BUSY) begin
      r_d = step_df[XLEN] ? step_t[XLEN-1:0] : step_df[XLEN-1:0];
      q_d = {q_q[XLEN-2:0], !step_df[XLEN]};
      cnt_d = cnt_q - 1'b1;
      state_d = (cnt_q == '0) ? DONE : BUSY;
    end else if (state_q == DONE && bus.es_to_ms_valid && bus.ms_allowin) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid_q <= 1'b0;
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      es_valid_q <= bus.flush ? 1'b0 : bus.es_allowin ? bus.ds_to_es_valid : es_valid_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (bus.ds_to_es_valid && bus.es_allowin) ds_q <= bus.ds_to_es_bus;
    r_q <= r_d;
    q_q <= q_d;
    d_q <= d_d;
  end
  // dword accesses only exist on 64-bit datapaths
  assign bytes = 4'd1 << size;
  assign ale = (re | we) & ((XLEN == 32 && size == 2'b11) |
               ((alu_res[AB-1:0] & AB'(bytes - 4'd1)) != '0));
  assign lane = ((NB + 1)'(1) << bytes) - 1'b1;
  assign mem_en = es_valid_q & (re | we) & !ale & bus.ms_allowin & !bus.flush;
  always_comb begin
    wdata = '0;
    for (int i = 0; i < NB; i++) wdata[8*i +: 8] = rkd[8*(i & (int'(bytes) - 1)) +: 8];
  end
  assign bus.data_sram_en = mem_en;
  assign bus.data_sram_wen = (mem_en & we) ? lane[NB-1:0] << alu_res[AB-1:0] : '0;
  assign bus.data_sram_addr = alu_res;
  assign bus.data_sram_wdata = wdata;
  assign bus.es_to_ms_bus = {ale, size, alu_res[1:0], re, gr_we, dest, result, pc};
  assign bus.es_to_ds_bus = {es_valid_q & gr_we & (dest != 5'd0), es_ready_go & !re, re, dest, result};
endmodule

// File: tb/tb_exe_stage_mdu.sv
// tb_exe_stage_mdu: table-driven scoreboard bench for the EX stage with divider
module tb_exe_stage_mdu;
  localparam logic [11:0] ADD = 12'h001, SUB = 12'h002, SLT = 12'h004, SLTU = 12'h008, SRA = 12'h400, NOP = 12'h000;
  localparam logic [2:0] ALU = 3'b000, DIV = 3'b101, MOD = 3'b111, DIVU = 3'b001, MODU = 3'b011;
  localparam int DL = 34;
  typedef struct {
    logic [11:0] op; logic [2:0] dv; logic re, we; logic [1:0] sz; logic s2i;
    logic [31:0] imm, rj, rkd, res; logic ale, en; logic [3:0] wen; logic [31:0] wd; int lat;
  } vec_t;
  typedef struct {
    logic [31:0] res, pc, wd; logic ale, en; logic [3:0] wen; int lat, cap;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  exp_t sb[$];
  exp_t me;
  vec_t vt[22];
  int errors = 0, checks = 0, cyc = 0;
  exe_stage_mdu_if #(.XLEN(32)) ifc();
  exe_stage_mdu #(.XLEN(32)) dut(.clk(clk), .reset(reset), .bus(ifc));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    if (!reset && ifc.es_to_ms_valid && ifc.ms_allowin) begin
      if (sb.size() == 0) chk("unexpected_out", 32'(ifc.es_to_ms_valid), 32'd0);
      else begin
        me = sb.pop_front();
        chk("result", ifc.es_to_ms_bus[63:32], me.res);
        chk("pc", ifc.es_to_ms_bus[31:0], me.pc);
        chk("ale", 32'(ifc.es_to_ms_bus[75]), 32'(me.ale));
        chk("sram_en", 32'(ifc.data_sram_en), 32'(me.en));
        chk("sram_wen", 32'(ifc.data_sram_wen), 32'(me.wen));
        chk("sram_wdata", ifc.data_sram_wdata, me.wd);
        if (me.en) chk("sram_addr", ifc.data_sram_addr, me.res);
        chk("latency", 32'(cyc - me.cap + 1), 32'(me.lat));
        chk("es_allowin", 32'(ifc.es_allowin), 32'd1);
        chk("fwd_data", ifc.es_to_ds_bus[31:0], me.res);
      end
    end
  end
  task automatic issue(input vec_t v, input logic [31:0] pc, input bit push, input int lat);
    exp_t e;
    bit ok;
    ok = 0;
    e = '{v.res, pc, v.wd, v.ale, v.en, v.wen, lat, 0};
    ifc.ds_to_es_valid = 1'b1;
    ifc.ds_to_es_bus = {v.op, v.dv, v.re, v.we, v.sz, 1'b0, v.s2i, 1'b1, 5'd5, v.imm, v.rj, v.rkd, pc};
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (ifc.es_allowin) begin
        ok = 1;
        e.cap = cyc + 1;
        if (push) sb.push_back(e);
      end
    end
    if (!ok) chk("issue_accept", 32'(ifc.es_allowin), 32'd1);
    @(posedge clk);
    #1;
    ifc.ds_to_es_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask
  task automatic idle_checks(input string n);
    @(negedge clk);
    chk({n, "_allowin"}, 32'(ifc.es_allowin), 32'd1);
    chk({n, "_to_ms_valid"}, 32'(ifc.es_to_ms_valid), 32'd0);
    chk({n, "_sram_en"}, 32'(ifc.data_sram_en), 32'd0);
    chk({n, "_sram_wen"}, 32'(ifc.data_sram_wen), 32'd0);
    chk({n, "_fwd_valid"}, 32'(ifc.es_to_ds_bus[39]), 32'd0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    ifc.ms_allowin = 1'b1;
    ifc.ds_to_es_valid = 1'b0;
    ifc.flush = 1'b0;
    ifc.ds_to_es_bus = '0;
    vt[0]  = '{ADD, ALU, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 4'h0, 32'd7, 1};
    vt[1]  = '{SUB, ALU, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0, 4'h0, 32'd7, 1};
    vt[2]  = '{SLT, ALU, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, 4'h0, 32'd1, 1};
    vt[3]  = '{SLTU, ALU, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 4'h0, 32'd1, 1};
    vt[4]  = '{SRA, ALU, 1'b0, 1'b0, 2'd2, 1'b1, 32'd4, 32'h80000000, 32'd0, 32'hF8000000, 1'b0, 1'b0, 4'h0, 32'd0, 1};
    vt[5]  = '{NOP, DIV, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 1'b0, 4'h0, 32'd2, DL};
    vt[6]  = '{NOP, MOD, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 1'b0, 4'h0, 32'd2, DL};
    vt[7]  = '{NOP, DIVU, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 4'h0, 32'd7, DL};
    vt[8]  = '{NOP, MODU, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 4'h0, 32'd7, DL};
    vt[9]  = '{NOP, DIVU, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h1234, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 4'h0, 32'd0, DL};
    vt[10] = '{NOP, MODU, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h1234, 32'd0, 32'h1234, 1'b0, 1'b0, 4'h0, 32'd0, DL};
    vt[11] = '{NOP, DIV, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 4'h0, 32'hFFFFFFFF, DL};
    vt[12] = '{NOP, MOD, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 4'h0, 32'hFFFFFFFF, DL};
    vt[13] = '{NOP, DIV, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0, 4'h0, 32'hFFFFFFFE, DL};
    vt[14] = '{NOP, MOD, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'd7, 32'hFFFFFFFE, 32'd1, 1'b0, 1'b0, 4'h0, 32'hFFFFFFFE, DL};
    vt[15] = '{ADD, ALU, 1'b0, 1'b1, 2'd0, 1'b1, 32'd3, 32'h1000, 32'hAB, 32'h1003, 1'b0, 1'b1, 4'b1000, 32'hABABABAB, 1};
    vt[16] = '{ADD, ALU, 1'b0, 1'b1, 2'd1, 1'b1, 32'd1, 32'h1000, 32'hBEEF, 32'h1001, 1'b1, 1'b0, 4'b0000, 32'hBEEFBEEF, 1};
    vt[17] = '{ADD, ALU, 1'b0, 1'b1, 2'd1, 1'b1, 32'd2, 32'h1000, 32'hBEEF, 32'h1002, 1'b0, 1'b1, 4'b1100, 32'hBEEFBEEF, 1};
    vt[18] = '{ADD, ALU, 1'b0, 1'b1, 2'd2, 1'b1, 32'd4, 32'h1000, 32'h12345678, 32'h1004, 1'b0, 1'b1, 4'b1111, 32'h12345678, 1};
    vt[19] = '{ADD, ALU, 1'b1, 1'b0, 2'd2, 1'b1, 32'd8, 32'h1000, 32'd0, 32'h1008, 1'b0, 1'b1, 4'b0000, 32'd0, 1};
    vt[20] = '{ADD, ALU, 1'b1, 1'b0, 2'd3, 1'b1, 32'd0, 32'h1000, 32'd0, 32'h1000, 1'b1, 1'b0, 4'b0000, 32'd0, 1};
    vt[21] = '{ADD, ALU, 1'b1, 1'b0, 2'd2, 1'b1, 32'd6, 32'h1000, 32'd0, 32'h1006, 1'b1, 1'b0, 4'b0000, 32'd0, 1};
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle_checks("reset");
    for (int i = 0; i < 22; i++) issue(vt[i], 32'h1c000000 + 32'(4 * i), 1'b1, vt[i].lat);
    drain();
    // load held in EX while MEM refuses it for three cycles
    ifc.ms_allowin = 1'b0;
    issue(vt[19], 32'h1c000100, 1'b1, 4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_sram_en", 32'(ifc.data_sram_en), 32'd0);
      chk("stall_allowin", 32'(ifc.es_allowin), 32'd0);
      chk("stall_fwd", 32'(ifc.es_to_ds_bus[39:37]), 32'b101);
      @(posedge clk);
      #1;
    end
    ifc.ms_allowin = 1'b1;
    @(negedge clk);
    chk("release_sram_en", 32'(ifc.data_sram_en), 32'd1);
    @(posedge clk);
    #1;
    drain();
    // flush during BUSY cycle 10 of a divide
    issue(vt[5], 32'h1c000200, 1'b0, 0);
    repeat (10) @(posedge clk);
    #1;
    ifc.flush = 1'b1;
    @(negedge clk);
    chk("flush_to_ms_valid", 32'(ifc.es_to_ms_valid), 32'd0);
    chk("flush_sram_en", 32'(ifc.data_sram_en), 32'd0);
    chk("flush_allowin", 32'(ifc.es_allowin), 32'd0);
    @(posedge clk);
    #1;
    ifc.flush = 1'b0;
    idle_checks("post_flush");
    issue(vt[0], 32'h1c000204, 1'b1, 1);
    issue(vt[5], 32'h1c000208, 1'b1, DL);
    drain();
    // reset during a divide
    issue(vt[6], 32'h1c000300, 1'b0, 0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_checks("mid_reset");
    issue(vt[0], 32'h1c000304, 1'b1, 1);
    issue(vt[6], 32'h1c000308, 1'b1, DL);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
